// File: rtl/jhash_stream.sv
// -----------------------------------------------------------------------------
// jhash_stream
// Producer side of the jhash block stream. Packs a word-serial message into
// 3x32-bit blocks and presents each block to jhash_core, holding it until the
// core acknowledges. A one-block pending slot lets the next block finish
// filling while the presented block waits for its acknowledge.
//
// Ports
//   clk            clock, all state on rising edge
//   rst            asynchronous active-high reset
//   in_data        message word
//   in_valid       in_data / in_last valid
//   in_last        in_data is the final word of the message
//   in_ready       word accepted when in_valid && in_ready
//   stream_data0-2 presented block, word 0 is the first word of the block
//   stream_valid   block presented, held stable until stream_ack
//   stream_done    presented block is the final block of its message
//   stream_left    number of valid words in the presented block (1..3)
//   stream_ack     consumer takes the presented block (single-cycle pulse)
//   msg_words      words accepted in the current / most recent message
// -----------------------------------------------------------------------------
module jhash_stream #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [31:0]      stream_data0,
    output logic [31:0]      stream_data1,
    output logic [31:0]      stream_data2,
    output logic             stream_valid,
    output logic             stream_done,
    output logic [1:0]       stream_left,
    input  logic             stream_ack,
    output logic [LEN_W-1:0] msg_words
);

    // pack stage
    logic [2:0][31:0] r_pack;
    logic [1:0]       r_widx;
    logic             r_pend;
    logic [1:0]       r_pend_left;
    logic             r_pend_done;

    // out stage
    logic [2:0][31:0] r_out;
    logic             r_valid;
    logic             r_done;
    logic [1:0]       r_left;

    logic [LEN_W-1:0] r_msg_words;
    logic             r_last_seen;

    logic             w_accept;
    logic             w_complete;
    logic             w_out_free;
    logic             w_ack;
    logic [2:0][31:0] w_blk;

    assign w_accept   = in_valid && !r_pend;
    assign w_complete = w_accept && ((r_widx == 2'd2) || in_last);
    // Acknowledge is only meaningful while a block is presented.
    assign w_ack      = stream_ack && r_valid;
    assign w_out_free = !r_valid || w_ack;

    // Block as it looks including the word being accepted this cycle. The pack
    // registers are cleared after every completion, so unfilled slots read 0.
    always_comb begin
        w_blk         = r_pack;
        w_blk[r_widx] = in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pack      <= '0;
            r_widx      <= 2'd0;
            r_pend      <= 1'b0;
            r_pend_left <= 2'd0;
            r_pend_done <= 1'b0;
        end else if (w_accept) begin
            if (w_complete) begin
                r_widx <= 2'd0;
                if (w_out_free) begin
                    r_pack <= '0;
                end else begin
                    r_pack      <= w_blk;
                    r_pend      <= 1'b1;
                    r_pend_left <= r_widx + 2'd1;
                    r_pend_done <= in_last;
                end
            end else begin
                r_pack[r_widx] <= in_data;
                r_widx         <= r_widx + 2'd1;
            end
        end else if (r_pend && w_ack) begin
            r_pack <= '0;
            r_pend <= 1'b0;
        end
    end

    // A direct load and a pending move can never coincide: while a block is
    // pending no word is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out   <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_left  <= 2'd0;
        end else if (w_complete && w_out_free) begin
            r_out   <= w_blk;
            r_valid <= 1'b1;
            r_left  <= r_widx + 2'd1;
            r_done  <= in_last;
        end else if (r_pend && w_ack) begin
            r_out   <= r_pack;
            r_valid <= 1'b1;
            r_left  <= r_pend_left;
            r_done  <= r_pend_done;
        end else if (w_ack) begin
            r_valid <= 1'b0;
        end
    end

    // The first word after a last word starts a fresh count at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_msg_words <= '0;
            r_last_seen <= 1'b0;
        end else if (w_accept) begin
            r_msg_words <= r_last_seen ? LEN_W'(1) : r_msg_words + LEN_W'(1);
            r_last_seen <= in_last;
        end
    end

    assign in_ready     = !r_pend;
    assign stream_data0 = r_out[0];
    assign stream_data1 = r_out[1];
    assign stream_data2 = r_out[2];
    assign stream_valid = r_valid;
    assign stream_done  = r_done;
    assign stream_left  = r_left;
    assign msg_words    = r_msg_words;

endmodule
